// File: rtl/mem_req_seq_if.sv
// Request/response and memory-controller bus for mem_req_seq.
// slave is the sequencer side, master is the upstream/memory environment side.
interface mem_req_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  err_timeout;
  logic                  mem_rd_enable;
  logic                  mem_wr_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_busy, mem_rd_data,
    output req_ready, rsp_valid, rsp_data, err_timeout,
           mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_busy, mem_rd_data,
    input  req_ready, rsp_valid, rsp_data, err_timeout,
           mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_req_seq.sv
// In-order request FIFO feeding a single-outstanding memory command sequencer
// with busy-handshake timeout detection and a sticky error flag.
module mem_req_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_req_seq_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_DONE
  } state_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             push;
  logic             pop;
  cmd_t             head;

  state_t                state;
  logic                  cmd_write;
  logic [7:0]            tmo_cnt;
  logic                  rd_enable;
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  assign ready = (count != FULL_CNT);
  assign push  = bus.req_valid && ready;
  assign pop   = (state == S_IDLE) && (count != '0) && !bus.mem_busy;
  assign head  = fifo_mem[rd_ptr];

  // Storage needs no reset: an entry is only read after its push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_write   <= 1'b0;
      tmo_cnt     <= '0;
      rd_enable   <= 1'b0;
      wr_enable   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // Strobes are set here so they are high for exactly the ISSUE cycle.
          if (pop) begin
            cmd_write <= head.write;
            addr_q    <= head.addr;
            wdata_q   <= head.wdata;
            wr_enable <= head.write;
            rd_enable <= !head.write;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wr_enable <= 1'b0;
          rd_enable <= 1'b0;
          tmo_cnt   <= '0;
          state     <= S_ACK;
        end
        S_ACK: begin
          if (bus.mem_busy) begin
            tmo_cnt <= '0;
            state   <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.mem_busy) begin
            if (!cmd_write) begin
              rsp_data_q  <= bus.mem_rd_data;
              rsp_valid_q <= 1'b1;
            end
            state <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.err_timeout   = err_q;
  assign bus.mem_rd_enable = rd_enable;
  assign bus.mem_wr_enable = wr_enable;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wr_data   = wdata_q;

endmodule

// File: tb/tb_mem_req_seq.sv
// Scoreboard bench for mem_req_seq: directed requests push expected strobes and
// responses; a negedge monitor with a small memory model pops and compares.
module tb_mem_req_seq;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_req_seq #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_cmd_t;

  exp_cmd_t      exp_cmd_q[$];
  logic [DW-1:0] exp_rsp_q[$];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_model [4096];
  logic [AW-1:0] rd_addr  = '0;
  logic [AW-1:0] cur_addr = '0;
  logic hold_busy  = 1'b0;
  logic model_busy = 1'b0;
  logic no_ack     = 1'b0;
  int busy_cnt = 0;
  int cyc = 0;
  int rd_strobe_cyc = 0;
  int n_acc = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_rsp = 0;
  int max_depth = 0;

  assign bus.mem_busy    = hold_busy | model_busy;
  assign bus.mem_rd_data = mem_model[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model + monitor: busy rises one cycle after a strobe and stays high 3 cycles.
  initial forever begin : monitor
    exp_cmd_t e;
    @(negedge clk);
    if (reset) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        chk("addr_hold", 32'(bus.mem_addr), 32'(cur_addr));
        busy_cnt--;
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'(1), 32'(0));
        else chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp_q.pop_front()));
      end
      if (bus.mem_wr_enable || bus.mem_rd_enable) begin
        chk("strobe_one_hot", 32'(bus.mem_wr_enable & bus.mem_rd_enable), 32'(0));
        chk("strobe_mem_idle", 32'((busy_cnt != 0) || bus.mem_busy), 32'(0));
        if (bus.mem_wr_enable) n_wr++;
        else n_rd++;
        if (exp_cmd_q.size() == 0) begin
          chk("strobe_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_cmd_q.pop_front();
          chk("strobe_kind", 32'(bus.mem_wr_enable), 32'(e.wr));
          chk("strobe_addr", 32'(bus.mem_addr), 32'(e.addr));
          if (e.wr) chk("strobe_wdata", 32'(bus.mem_wr_data), 32'(e.data));
          cur_addr = e.addr;
        end
        if (bus.mem_wr_enable) mem_model[bus.mem_addr] = bus.mem_wr_data;
        else begin
          rd_addr = bus.mem_addr;
          rd_strobe_cyc = cyc;
        end
        if (no_ack) no_ack = 1'b0;
        else busy_cnt = 4;
      end
      model_busy = (busy_cnt >= 1) && (busy_cnt <= 3);
    end
  end

  task automatic push_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic exp_rsp, input logic [DW-1:0] rd_exp);
    int n = 0;
    exp_cmd_t c;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("push_ready_timeout", 32'(0), 32'(1));
      bus.req_valid = 1'b0;
      return;
    end
    c.wr = wr;
    c.addr = a;
    c.data = d;
    exp_cmd_q.push_back(c);
    if (exp_rsp) exp_rsp_q.push_back(rd_exp);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_acc++;
    if (n_acc - n_wr - n_rd > max_depth) max_depth = n_acc - n_wr - n_rd;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0 || busy_cnt != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(n < 300), 32'(1));
    repeat (6) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int w0, r0, s0, a0;
    logic [AW-1:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    for (int unsigned i = 0; i < 4096; i++) mem_model[i] = 8'(i * 7 + 3);

    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(bus.mem_rd_enable), 32'(0));
    chk("rst_wr_en", 32'(bus.mem_wr_enable), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_err", 32'(bus.err_timeout), 32'(0));
    chk("rst_addr", 32'(bus.mem_addr), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'(1));

    // Single write
    w0 = n_wr; r0 = n_rd; s0 = n_rsp;
    push_req(1'b1, 12'h123, 8'hA5, 1'b0, 8'h00);
    wait_drain("t1");
    chk("t1_wr_pulses", 32'(n_wr - w0), 32'(1));
    chk("t1_rd_pulses", 32'(n_rd - r0), 32'(0));
    chk("t1_rsp_count", 32'(n_rsp - s0), 32'(0));

    // Write then read-back of the same address
    s0 = n_rsp;
    push_req(1'b1, 12'h010, 8'h5A, 1'b0, 8'h00);
    push_req(1'b0, 12'h010, 8'h00, 1'b1, 8'h5A);
    wait_drain("t2");
    chk("t2_rsp_count", 32'(n_rsp - s0), 32'(1));

    // Fill FIFO while memory is busy; fifth request must wait
    s0 = n_rsp; a0 = n_acc; w0 = n_wr; r0 = n_rd;
    hold_busy = 1'b1;
    push_req(1'b1, 12'h100, 8'h11, 1'b0, 8'h00);
    push_req(1'b1, 12'h101, 8'h22, 1'b0, 8'h00);
    push_req(1'b0, 12'h100, 8'h00, 1'b1, 8'h11);
    push_req(1'b1, 12'h102, 8'h33, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("t3_ready_low", 32'(bus.req_ready), 32'(0));
    chk("t3_accepted", 32'(n_acc - a0), 32'(4));
    chk("t3_no_strobe_while_busy", 32'((n_wr - w0) + (n_rd - r0)), 32'(0));
    fork
      push_req(1'b0, 12'h101, 8'h00, 1'b1, 8'h22);
      begin
        repeat (5) @(negedge clk);
        chk("t3_ready_still_low", 32'(bus.req_ready), 32'(0));
        chk("t3_fifth_held", 32'(n_acc - a0), 32'(4));
        hold_busy = 1'b0;
      end
    join
    wait_drain("t3");
    chk("t3_rsp_count", 32'(n_rsp - s0), 32'(2));
    chk("t3_depth_bound", 32'(max_depth <= DEPTH), 32'(1));

    // Read never acknowledged -> timeout, then the queued write still runs
    s0 = n_rsp; w0 = n_wr;
    no_ack = 1'b1;
    push_req(1'b0, 12'h200, 8'h00, 1'b0, 8'h00);
    push_req(1'b1, 12'h201, 8'h44, 1'b0, 8'h00);
    begin
      int n = 0;
      while (!bus.err_timeout && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_err_set", 32'(bus.err_timeout), 32'(1));
    chk("t4_err_latency", 32'(cyc - rd_strobe_cyc), 32'(TMO + 1));
    wait_drain("t4");
    chk("t4_err_sticky", 32'(bus.err_timeout), 32'(1));
    chk("t4_rsp_count", 32'(n_rsp - s0), 32'(0));
    chk("t4_write_after", 32'(n_wr - w0), 32'(1));

    // Reset while in DONE with two more queued
    push_req(1'b1, 12'h300, 8'h77, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    hold_busy = 1'b1;
    push_req(1'b0, 12'h301, 8'h00, 1'b0, 8'h00);
    push_req(1'b1, 12'h302, 8'h78, 1'b0, 8'h00);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rd_en", 32'(bus.mem_rd_enable), 32'(0));
    chk("t5_wr_en", 32'(bus.mem_wr_enable), 32'(0));
    chk("t5_addr", 32'(bus.mem_addr), 32'(0));
    chk("t5_wdata", 32'(bus.mem_wr_data), 32'(0));
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("t5_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("t5_err", 32'(bus.err_timeout), 32'(0));
    chk("t5_ready", 32'(bus.req_ready), 32'(1));
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    hold_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_acc = n_wr + n_rd;
    w0 = n_wr; r0 = n_rd;
    repeat (20) @(negedge clk);
    chk("t5_no_strobes", 32'((n_wr - w0) + (n_rd - r0)), 32'(0));
    chk("t5_ready_after", 32'(bus.req_ready), 32'(1));

    // Stream of 20 reads through the FIFO with pointer wrap
    s0 = n_rsp; r0 = n_rd; max_depth = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      a = 12'(12'h800 + i * 5);
      push_req(1'b0, a, 8'h00, 1'b1, 8'(a * 7 + 3));
    end
    wait_drain("t6");
    chk("t6_rsp_count", 32'(n_rsp - s0), 32'(20));
    chk("t6_rd_count", 32'(n_rd - r0), 32'(20));
    chk("t6_depth_bound", 32'(max_depth <= DEPTH), 32'(1));
    chk("t6_err_clear", 32'(bus.err_timeout), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
